// File: rtl/mips_debug_pkg.sv
// Shared constants and types for the debug trace capture block.
package mips_debug_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int         FRAME_BYTES = 13;
  localparam int         REC_W       = 96;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO. Head is read combinationally. A push while full
// is still accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 96,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  din,
  input  logic              pop,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Accept logic and pointer/count update; pointers wrap naturally
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mips_trace_capture.sv
// Captures one {pc, alu, mem} record per PC change, buffers it and streams
// 13-byte frames (header + 12 data bytes, MSB first) on a valid/ready port.
//
// state   | meaning
// IDLE    | no frame in flight, waiting for a buffered record
// SEND    | frame in flight, byte_idx selects the byte on out_data
module mips_trace_capture
  import mips_debug_pkg::*;
#(
  parameter int         DEPTH  = 8,
  parameter int         ADDR_W = 3,
  parameter logic [7:0] HEADER = HEADER_BYTE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       mem_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic [15:0]       dropped_count
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  ser_state_e        state_q, state_d;
  logic [REC_W-1:0]  rec_q, rec_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       last_pc_q, last_pc_d;
  logic              first_q, first_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       dropped_q, dropped_d;

  logic              capture;
  logic              pop;
  logic              drop;
  logic [REC_W-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  trace_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (REC_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (capture),
    .din   ({pc_in, alu_in, mem_in}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Capture detection and drop accounting
  always_comb begin
    capture    = enable && (first_q || (pc_in != last_pc_q));
    drop       = capture && fifo_full && !pop;
    last_pc_d  = capture ? pc_in : last_pc_q;
    first_d    = capture ? 1'b0 : first_q;
    overflow_d = overflow_q | drop;
    dropped_d  = dropped_q;
    if (drop && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
  end

  // Serializer next state; a new record is loaded only on the last byte
  // transfer or from IDLE so the stream never shows a bubble mid-burst
  always_comb begin
    state_d    = state_q;
    rec_d      = rec_q;
    byte_idx_d = byte_idx_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          rec_d      = fifo_dout;
          byte_idx_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (byte_idx_q == LAST_IDX) begin
            if (!fifo_empty) begin
              pop        = 1'b1;
              rec_d      = fifo_dout;
              byte_idx_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            // header does not consume record bits
            if (byte_idx_q != 4'd0) rec_d = rec_q << 8;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs derive from registered state, so they hold while stalled
  always_comb begin
    out_valid     = (state_q == ST_SEND);
    out_last      = out_valid && (byte_idx_q == LAST_IDX);
    out_data      = 8'h00;
    if (out_valid) out_data = (byte_idx_q == 4'd0) ? HEADER : rec_q[REC_W-1 -: 8];
    overflow      = overflow_q;
    dropped_count = dropped_q;
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rec_q      <= '0;
      byte_idx_q <= '0;
      last_pc_q  <= '0;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      rec_q      <= rec_d;
      byte_idx_q <= byte_idx_d;
      last_pc_q  <= last_pc_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

endmodule

// File: tb/tb_mips_trace_capture.sv
// Directed bench for mips_trace_capture: frame contents, back-to-back frames,
// overflow, stalls, enable gating and asynchronous reset mid-frame.
module tb_mips_trace_capture;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] pc_in, alu_in, mem_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] dropped_count;

  int errors = 0;
  int checks = 0;

  mips_trace_capture #(.DEPTH(8), .ADDR_W(3), .HEADER(8'hA5)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .pc_in         (pc_in),
    .alu_in        (alu_in),
    .mem_in        (mem_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .dropped_count (dropped_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input logic [95:0] r, input int i);
    if (i == 0) return 8'hA5;
    return r[95 - 8*(i-1) -: 8];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    pc_in     = '0;
    alu_in    = '0;
    mem_in    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  // Consumes one frame, checking each byte and out_last; with toggle the
  // ready line alternates and stalled outputs must hold; with no_gap any
  // cycle without out_valid is an error.
  task automatic expect_frame(input logic [95:0] rec, input bit toggle,
                              input bit no_gap, input string name);
    int i = 0;
    int waits = 0;
    bit stalled = 0;
    bit gap_seen = 0;
    logic [7:0] sd = '0;
    logic sl = 1'b0;
    logic [7:0] eb;
    while (i < 13) begin
      if (toggle) out_ready = ~out_ready;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== sd || out_last !== sl) begin
          errors++;
          $display("FAIL %s_stall_hold byte %0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   name, i, out_valid, out_data, out_last, sd, sl);
        end
      end
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          eb = exp_byte(rec, i);
          checks++;
          if (out_data !== eb) begin
            errors++;
            $display("FAIL %s_data byte %0d: got %h, want %h", name, i, out_data, eb);
          end
          checks++;
          if (out_last !== (i == 12)) begin
            errors++;
            $display("FAIL %s_last byte %0d: got %b, want %b", name, i, out_last, (i == 12));
          end
          i++;
          stalled = 0;
        end else begin
          stalled = 1;
          sd = out_data;
          sl = out_last;
        end
      end else begin
        stalled = 0;
        if (no_gap && !gap_seen) begin
          gap_seen = 1;
          checks++;
          errors++;
          $display("FAIL %s_gap byte %0d: got out_valid=0, want 1", name, i);
        end
        waits++;
        if (waits > 40) begin
          checks++;
          errors++;
          $display("FAIL %s_timeout: got %0d bytes, want 13", name, i);
          if (toggle) out_ready = 1'b1;
          return;
        end
      end
      step();
    end
    if (toggle) out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0; out_ready = 1'b0;
    pc_in = '0; alu_in = '0; mem_in = '0;
    #3;
    checks++;
    if ({out_data, out_valid, out_last, fifo_count, overflow, dropped_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got d=%h v=%b l=%b cnt=%0d ovf=%b drop=%0d, want all 0",
               out_data, out_valid, out_last, fifo_count, overflow, dropped_count);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [95:0] rec;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    pc_in = 32'h0; alu_in = 32'h5; mem_in = 32'hDEADBEEF;
    rec = {32'h0, 32'h5, 32'hDEADBEEF};
    step();
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd1) begin
      errors++;
      $display("FAIL single_capture_edge: got v=%b cnt=%0d, want v=0 cnt=1", out_valid, fifo_count);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL single_latency: got v=%b d=%h cnt=%0d, want v=1 d=a5 cnt=0",
               out_valid, out_data, fifo_count);
    end
    expect_frame(rec, 0, 1, "single");
    repeat (3) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_after: got out_valid=%b, want 0", out_valid);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pc_in = pcs[k]; alu_in = 32'h1000 + pcs[k]; mem_in = 32'hC0DE0000 | pcs[k];
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      expect_frame({pcs[k], 32'h1000 + pcs[k], 32'hC0DE0000 | pcs[k]}, 0, 1, "b2b");
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL b2b_end: got v=%b cnt=%0d, want v=0 cnt=0", out_valid, fifo_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pc_in = 32'h100 + 4*k; alu_in = 32'hA0 + k; mem_in = 32'hFACE0000 + k;
      step();
      if (k >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0) begin
          errors++;
          $display("FAIL ovf_hold k=%0d: got v=%b d=%h l=%b, want v=1 d=a5 l=0",
                   k, out_valid, out_data, out_last);
        end
      end
    end
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || dropped_count !== 16'd1) begin
      errors++;
      $display("FAIL ovf_state: got cnt=%0d ovf=%b drop=%0d, want cnt=8 ovf=1 drop=1",
               fifo_count, overflow, dropped_count);
    end
    enable = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 9; k++)
      expect_frame({32'h100 + 4*k, 32'hA0 + k, 32'hFACE0000 + k}, 0, 1, "ovf_drain");
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b1 || dropped_count !== 16'd1) begin
      errors++;
      $display("FAIL ovf_end: got v=%b cnt=%0d ovf=%b drop=%0d, want v=0 cnt=0 ovf=1 drop=1",
               out_valid, fifo_count, overflow, dropped_count);
    end
  endtask

  task automatic test_stall_toggle();
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    pc_in = 32'h1234_5678; alu_in = 32'h9ABC_DEF0; mem_in = 32'h0F1E_2D3C;
    step();
    enable = 1'b0;
    step();
    expect_frame({32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C}, 1, 0, "toggle");
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL toggle_end: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pc_in = 32'h300 + 4*k;
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL enable_off: got v=%b cnt=%0d, want v=0 cnt=0", out_valid, fifo_count);
    end
    pc_in = 32'h200; alu_in = 32'h77; mem_in = 32'h88;
    enable = 1'b1;
    step();
    enable = 1'b0;
    expect_frame({32'h200, 32'h77, 32'h88}, 0, 0, "enable_on");
    pc_in = 32'h300; step();
    pc_in = 32'h304; step();
    pc_in = 32'h200; enable = 1'b1;
    repeat (4) step();
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL enable_same_pc: got v=%b cnt=%0d, want v=0 cnt=0", out_valid, fifo_count);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [95:0] rec;
    int w;
    rec = {32'h5000_0504, 32'h55, 32'h5A5A_5A5A};
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    pc_in = rec[95:64]; alu_in = rec[63:32]; mem_in = rec[31:0];
    w = 0;
    while (out_valid !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    repeat (4) step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h04) begin
      errors++;
      $display("FAIL rst_mid_byte5: got v=%b d=%h, want v=1 d=04", out_valid, out_data);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, out_last, fifo_count, overflow, dropped_count} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got d=%h v=%b l=%b cnt=%0d ovf=%b drop=%0d, want all 0",
               out_data, out_valid, out_last, fifo_count, overflow, dropped_count);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
    expect_frame(rec, 0, 0, "rst_restart");
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_stall_toggle();
    test_enable();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
